apb_reg_arbiter: RTL and testbench
==================================

// Module: apb_reg_arbiter
// PURPOSE
//  Shares the single APB slave port of a generated register bank between two
//  requesters: req0 (firmware/CPU) and req1 (debug/JTAG-to-reg bridge).
//  Round-robin grant; one transfer in flight; APB master sequencing (SETUP/ACCESS).
//  PREADY wait states are supported, with a timeout and error reporting.
//  Sits between the requesters and the *_regs_top APB port.
// PARAMETERS
//  ADDR_WIDTH  8   APB address width; matches the register bank.
//  TIMEOUT     16  Max ACCESS cycles without PREADY before abort; 0 = no timeout.
// PORTS
//  RegClk       in   1          clock
//  RegReset     in   1          asynchronous, active-high reset
//  req_valid    in   2          per-requester transfer request; held until req_ready
//  req_write    in   2          1 = write, 0 = read
//  req_addr     in   2*AW       {req1_addr, req0_addr}
//  req_wdata    in   64         {req1_wdata, req0_wdata}
//  req_ready    out  2          one-cycle accept pulse to the granted requester
//  rsp_valid    out  2          one-cycle completion pulse to the owning requester
//  rsp_rdata    out  32         read data; valid with rsp_valid; 0 for writes/timeouts
//  rsp_err      out  1          PSLVERR or timeout; valid with rsp_valid
//  grant_id     out  1          requester owning the current or last transfer
//  busy         out  1          1 while in SETUP or ACCESS
//  err_count    out  8          saturating count of error completions
//  PSEL         out  1          APB master select
//  PENABLE      out  1          APB master enable
//  PWRITE       out  1          APB master write
//  PADDR        out  AW         APB master address
//  PWDATA       out  32         APB master write data
//  PRDATA       in   32         APB read data
//  PREADY       in   1          APB ready
//  PSLVERR      in   1          APB slave error
// BEHAVIOUR
//  Reset
//   - All outputs are 0.
//   - last_grant = 1, so req0 wins the first contest.
//   - FSM = IDLE.
//  FSM
//   - IDLE: if any req_valid, select g.
//     - Exactly one valid: g is that requester.
//     - Both valid: g = ~last_grant.
//     - req_ready[g] is combinational in this cycle.
//     - Capture addr/wdata/write on this edge; last_grant <= g; go to SETUP.
//   - SETUP: PSEL=1, PENABLE=0; addr/write/wdata driven from the captured regs. Next state: ACCESS.
//   - ACCESS: PSEL=1, PENABLE=1.
//     - PREADY=1: capture PRDATA (reads only, else 0) and PSLVERR; go to IDLE.
//     - PREADY=0: increment wait counter; hold PADDR, PWDATA and PWRITE stable.
//     - Timeout: if TIMEOUT != 0 and the counter reaches TIMEOUT with no PREADY, abort.
//       Abort goes to IDLE with rdata=0, err=1.
//  Response
//   - rsp_valid[grant_id] is a registered pulse in the first IDLE cycle after ACCESS ends.
//   - That same IDLE cycle can accept the next request.
//   - Throughput: one transfer per 3 cycles with PREADY=1.
//   - Latency: req_ready to rsp_valid is 3 cycles with PREADY=1 (+1 per wait state).
//  Register and counter rules
//   - rsp_rdata and rsp_err hold their values until the next completion.
//   - err_count increments on each rsp_err completion and saturates at 8'hFF.
//   - The wait counter clears on entry to ACCESS.
//  Requester rules
//   - Requesters must hold valid, addr, wdata and write until req_ready.
//   - A valid dropped before ready is simply not served (no error).
//   - A requester may re-request in its own rsp_valid cycle.
//  Reset mid-transfer: outputs clear immediately; no response is issued; last_grant = 1.
//  PSEL never drops between SETUP and ACCESS. PENABLE is never 1 without PSEL.
// TESTING
//  T1: req0 write addr 0x04 wdata 0x1, PREADY=1.
//      -> req_ready[0] in cycle 0; PSEL=1/PENABLE=0 in cycle 1; PENABLE=1 in cycle 2.
//      -> rsp_valid=2'b01 in cycle 3; rsp_err=0.
//  T2: both requesters hold valid continuously from reset, 6 transfers.
//      -> grant order 0,1,0,1,0,1; one transfer every 3 cycles.
//  T3: req1 read addr 0x20; slave returns PSLVERR=1, PRDATA=0xDEAD.
//      -> rsp_valid=2'b10, rsp_err=1, rsp_rdata=0xDEAD, err_count=1.
//  T4: PREADY held low, TIMEOUT=16.
//      -> PSEL deasserts after 16 ACCESS cycles; rsp_err=1, rsp_rdata=0.
//  T5: PREADY low for 3 ACCESS cycles, then high on a read.
//      -> PADDR/PWDATA/PWRITE stable; rsp at req_ready+6; correct rdata.
//  T6: RegReset pulsed during ACCESS.
//      -> PSEL/PENABLE=0 immediately; no rsp_valid.
//      -> next contest with both valid grants req0.

Source files
------------

// File: rtl/apb_reg_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port into a register bank.
// One transfer in flight; PREADY wait states with an optional timeout abort.
module apb_reg_arbiter #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                    RegClk,
   input  logic                    RegReset,
   input  logic [1:0]              req_valid,
   input  logic [1:0]              req_write,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [63:0]             req_wdata,
   output logic [1:0]              req_ready,
   output logic [1:0]              rsp_valid,
   output logic [31:0]             rsp_rdata,
   output logic                    rsp_err,
   output logic                    grant_id,
   output logic                    busy,
   output logic [7:0]              err_count,
   output logic                    PSEL,
   output logic                    PENABLE,
   output logic                    PWRITE,
   output logic [ADDR_WIDTH-1:0]   PADDR,
   output logic [31:0]             PWDATA,
   input  logic [31:0]             PRDATA,
   input  logic                    PREADY,
   input  logic                    PSLVERR
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StSetup  = 2'd1;
   localparam logic [1:0] StAccess = 2'd2;

   // Counter only needs to reach TIMEOUT-1; it simply wraps when TIMEOUT is 0.
   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [1:0]            state_q, state_d;
   logic                  last_grant_q;
   logic                  grant_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic                  write_q;
   logic [CntW-1:0]       wait_cnt_q;
   logic [1:0]            rsp_valid_q;
   logic [31:0]           rsp_rdata_q;
   logic                  rsp_err_q;
   logic [7:0]            err_count_q;

   logic grant_sel;
   logic start;
   logic done_ok;
   logic timed_out;
   logic finish;
   logic fin_err;

   always_comb begin
      // Contest goes to the requester that did not win last time.
      grant_sel = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
      start     = (state_q == StIdle) && (|req_valid);
      req_ready = start ? {grant_sel, ~grant_sel} : 2'b00;
      done_ok   = (state_q == StAccess) && PREADY;
      timed_out = (state_q == StAccess) && !PREADY && (TIMEOUT != 0) &&
                  (wait_cnt_q == CntW'(TIMEOUT - 1));
      finish    = done_ok || timed_out;
      fin_err   = timed_out || PSLVERR;
      state_d   = state_q;
      case (state_q)
         StIdle:   if (start) state_d = StSetup;
         StSetup:  state_d = StAccess;
         StAccess: if (finish) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge RegClk or posedge RegReset) begin
      if (RegReset) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         write_q      <= 1'b0;
         wait_cnt_q   <= '0;
         rsp_valid_q  <= 2'b00;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
         err_count_q  <= '0;
      end else begin
         state_q <= state_d;
         if (start) begin
            last_grant_q <= grant_sel;
            grant_q      <= grant_sel;
            addr_q       <= grant_sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                      : req_addr[ADDR_WIDTH-1:0];
            wdata_q      <= grant_sel ? req_wdata[63:32] : req_wdata[31:0];
            write_q      <= grant_sel ? req_write[1] : req_write[0];
         end
         if (state_q == StSetup) begin
            wait_cnt_q <= '0;
         end else if ((state_q == StAccess) && !PREADY) begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
         end
         rsp_valid_q <= finish ? {grant_q, ~grant_q} : 2'b00;
         if (finish) begin
            rsp_rdata_q <= (done_ok && !write_q) ? PRDATA : 32'h0;
            rsp_err_q   <= fin_err;
            if (fin_err && (err_count_q != 8'hFF)) begin
               err_count_q <= err_count_q + 8'd1;
            end
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign grant_id  = grant_q;
   assign busy      = (state_q != StIdle);
   assign err_count = err_count_q;
   assign PSEL      = (state_q != StIdle);
   assign PENABLE   = (state_q == StAccess);
   assign PWRITE    = write_q;
   assign PADDR     = addr_q;
   assign PWDATA    = wdata_q;

endmodule

// File: tb/tb_apb_reg_arbiter.sv
// Directed bench for apb_reg_arbiter: round-robin order, APB sequencing, wait states,
// slave error, timeout abort and reset during a transfer.
module tb_apb_reg_arbiter;

   logic        RegClk = 1'b0;
   logic        RegReset;
   logic [1:0]  req_valid, req_write;
   logic [15:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  req_ready, rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err, grant_id, busy;
   logic [7:0]  err_count;
   logic        PSEL, PENABLE, PWRITE;
   logic [7:0]  PADDR;
   logic [31:0] PWDATA, PRDATA;
   logic        PREADY, PSLVERR;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 RegClk = ~RegClk;

   apb_reg_arbiter #(.ADDR_WIDTH(8), .TIMEOUT(16)) dut (
      .RegClk(RegClk), .RegReset(RegReset),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .grant_id(grant_id), .busy(busy),
      .err_count(err_count), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge RegClk);
      #2;
   endtask

   initial begin
      int n_acc;
      logic exp_g;

      RegReset  = 1'b1;
      req_valid = 2'b00;
      req_write = 2'b00;
      req_addr  = '0;
      req_wdata = '0;
      PRDATA    = '0;
      PREADY    = 1'b1;
      PSLVERR   = 1'b0;
      #3;
      check_val("rst_psel", {PENABLE, PSEL}, 0);
      check_val("rst_rsp", {rsp_err, rsp_valid}, 0);
      check_val("rst_misc", {grant_id, busy, err_count}, 0);
      tick();
      RegReset = 1'b0;
      tick();

      // T2: both requesters always valid, six transfers alternate starting with req0.
      req_valid = 2'b11;
      req_write = 2'b11;
      req_addr  = {8'h11, 8'h10};
      req_wdata = {32'h0000_00B1, 32'h0000_00A0};
      for (int k = 0; k < 6; k++) begin
         exp_g = k[0];
         #1;
         check_val("t2_ready", req_ready, exp_g ? 2 : 1);
         if (k > 0) check_val("t2_rsp", rsp_valid, exp_g ? 1 : 2);
         tick();
         #1;
         check_val("t2_paddr", PADDR, exp_g ? 32'h11 : 32'h10);
         check_val("t2_pwdata", PWDATA, exp_g ? 32'hB1 : 32'hA0);
         tick();
         tick();
      end
      req_valid = 2'b00;
      #1;
      check_val("t2_last_rsp", rsp_valid, 2);
      tick();

      // T1: req0 write 0x04 <- 0x1.
      req_valid = 2'b01;
      req_write = 2'b01;
      req_addr  = {8'h00, 8'h04};
      req_wdata = {32'h0, 32'h1};
      #1;
      check_val("t1_ready", req_ready, 1);
      check_val("t1_busy0", busy, 0);
      tick();
      req_valid = 2'b00;
      #1;
      check_val("t1_setup", {PSEL, PENABLE}, 2'b10);
      check_val("t1_apb", {PWRITE, PADDR, PWDATA[7:0]}, {1'b1, 8'h04, 8'h01});
      check_val("t1_ready_gone", req_ready, 0);
      tick();
      #1;
      check_val("t1_access", {PSEL, PENABLE}, 2'b11);
      tick();
      #1;
      check_val("t1_rsp", rsp_valid, 1);
      check_val("t1_err", {rsp_err, rsp_rdata}, 0);
      check_val("t1_idle", {PSEL, busy, grant_id}, 0);
      tick();
      #1;
      check_val("t1_rsp_pulse", rsp_valid, 0);

      // T3: req1 read 0x20 with slave error and PRDATA=0xDEAD.
      req_valid = 2'b10;
      req_write = 2'b00;
      req_addr  = {8'h20, 8'h00};
      #1;
      check_val("t3_ready", req_ready, 2);
      tick();
      req_valid = 2'b00;
      #1;
      check_val("t3_setup", {PWRITE, PADDR}, {1'b0, 8'h20});
      tick();
      PRDATA  = 32'h0000_DEAD;
      PSLVERR = 1'b1;
      tick();
      PSLVERR = 1'b0;
      PRDATA  = '0;
      #1;
      check_val("t3_rsp", rsp_valid, 2);
      check_val("t3_err", rsp_err, 1);
      check_val("t3_rdata", rsp_rdata, 32'hDEAD);
      check_val("t3_errcnt", err_count, 1);
      check_val("t3_gid", grant_id, 1);

      // T5: req0 read 0x30, three wait states, then data.
      tick();
      req_valid = 2'b01;
      req_write = 2'b00;
      req_addr  = {8'h00, 8'h30};
      #1;
      check_val("t5_ready", req_ready, 1);
      tick();
      req_valid = 2'b00;
      PREADY    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         check_val("t5_hold", {PSEL, PENABLE, PWRITE, PADDR}, {3'b110, 8'h30});
      end
      tick();
      PREADY = 1'b1;
      PRDATA = 32'h1234_5678;
      tick();
      PRDATA = '0;
      #1;
      check_val("t5_rsp", rsp_valid, 1);
      check_val("t5_rdata", rsp_rdata, 32'h1234_5678);
      check_val("t5_err", {rsp_err, err_count}, {1'b0, 8'd1});

      // T4: req1 write, PREADY never rises; abort after 16 ACCESS cycles.
      tick();
      req_valid = 2'b10;
      req_write = 2'b10;
      req_addr  = {8'h40, 8'h00};
      req_wdata = {32'hAB, 32'h0};
      PREADY    = 1'b0;
      #1;
      check_val("t4_ready", req_ready, 2);
      tick();
      req_valid = 2'b00;
      n_acc = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         #1;
         if (rsp_valid != 2'b00) break;
         if (PENABLE) n_acc++;
      end
      check_val("t4_access_cycles", n_acc, 16);
      check_val("t4_rsp", rsp_valid, 2);
      check_val("t4_psel", {PSEL, PENABLE}, 0);
      check_val("t4_err", {rsp_err, rsp_rdata}, {1'b1, 32'h0});
      check_val("t4_errcnt", err_count, 2);

      // T6: reset asserted during ACCESS of a req0 transfer.
      tick();
      req_valid = 2'b01;
      req_write = 2'b01;
      req_addr  = {8'h00, 8'h50};
      #1;
      check_val("t6_ready", req_ready, 1);
      tick();
      req_valid = 2'b00;
      tick();
      #1;
      check_val("t6_access", PENABLE, 1);
      RegReset = 1'b1;
      #1;
      check_val("t6_rst_apb", {PSEL, PENABLE, busy}, 0);
      check_val("t6_rst_cnt", err_count, 0);
      tick();
      RegReset = 1'b0;
      PREADY   = 1'b1;
      #1;
      check_val("t6_no_rsp0", rsp_valid, 0);
      tick();
      #1;
      check_val("t6_no_rsp1", rsp_valid, 0);
      req_valid = 2'b11;
      #1;
      check_val("t6_contest", req_ready, 1);
      tick();
      req_valid = 2'b00;
      tick();
      tick();
      #1;
      check_val("t6_rsp", rsp_valid, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
